// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit : multi-cycle MIPS mult/multu/div/divu engine with HI/LO
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_rd,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIN  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_divz;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_wh;
  logic [WIDTH-1:0] r_wl;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0] w_fin_hi;
  logic [WIDTH-1:0] w_fin_lo;

  assign w_a_neg = ~op[0] & a[WIDTH-1];
  assign w_b_neg = ~op[0] & b[WIDTH-1];
  assign w_a_abs = w_a_neg ? -a : a;
  assign w_b_abs = w_b_neg ? -b : b;

  // Multiply: {r_wh,r_wl} is the partial product with the multiplier shifting
  // out of r_wl. Divide: r_wh is the partial remainder, r_wl shifts the
  // dividend out and the quotient in.
  assign w_sum  = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_m} : '0);
  assign w_sh   = {r_wh, r_wl[WIDTH-1]};
  assign w_ge   = w_sh >= {1'b0, r_m};
  assign w_diff = w_sh[WIDTH-1:0] - r_m;

  always_comb begin
    w_step_hi = w_sum[WIDTH:1];
    w_step_lo = {w_sum[0], r_wl[WIDTH-1:1]};
    if (r_is_div) begin
      w_step_hi = w_ge ? w_diff : w_sh[WIDTH-1:0];
      w_step_lo = {r_wl[WIDTH-2:0], w_ge};
    end
  end

  assign w_prod_neg = -{r_wh, r_wl};

  always_comb begin
    w_fin_hi = r_wh;
    w_fin_lo = r_wl;
    if (r_divz) begin
      w_fin_hi = r_wh;
      w_fin_lo = r_wl;
    end else if (r_is_div) begin
      w_fin_hi = r_neg_r ? -r_wh : r_wh;
      w_fin_lo = r_neg_q ? -r_wl : r_wl;
    end else if (r_neg_q) begin
      w_fin_hi = w_prod_neg[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_m      <= '0;
      r_wh     <= '0;
      r_wl     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (mthi) r_hi <= a;
          if (mtlo) r_lo <= a;
          if (start && !flush) begin
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_m      <= w_b_abs;
            r_count  <= '0;
            if (op[1] && (b == '0)) begin
              // Divide by zero: final result is staged directly
              r_divz  <= 1'b1;
              r_wh    <= a;
              r_wl    <= '1;
              r_state <= c_FIN;
            end else begin
              r_divz  <= 1'b0;
              r_wh    <= '0;
              r_wl    <= w_a_abs;
              r_state <= c_CALC;
            end
          end
        end
        c_CALC: begin
          if (flush) begin
            r_state <= c_IDLE;
          end else begin
            r_wh    <= w_step_hi;
            r_wl    <= w_step_lo;
            r_count <= r_count + CW'(1);
            if (r_count == c_LAST) r_state <= c_FIN;
          end
        end
        c_FIN: begin
          r_state <= c_IDLE;
          if (!flush) begin
            r_hi   <= w_fin_hi;
            r_lo   <= w_fin_lo;
            r_done <= 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy  = (r_state != c_IDLE);
  assign stall = busy & (start | mf_rd | mthi | mtlo);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit : directed + random checks of muldiv_unit against a model
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mf_rd = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mf_rd(mf_rd), .mthi(mthi), .mtlo(mtlo), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands
  task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint      sp, sq, sr;
    logic [63:0] up;
    lat = 33;
    case (mop)
      2'b00: begin
        sp = longint'($signed(ma)) * longint'($signed(mb));
        up = sp;
        eh = up[63:32]; el = up[31:0];
      end
      2'b01: begin
        up = {32'd0, ma} * {32'd0, mb};
        eh = up[63:32]; el = up[31:0];
      end
      default: begin
        if (mb == 32'd0) begin
          eh = ma; el = 32'hFFFF_FFFF; lat = 1;
        end else if (mop == 2'b10) begin
          sq = longint'($signed(ma)) / longint'($signed(mb));
          sr = longint'($signed(ma)) % longint'($signed(mb));
          up = sq; el = up[31:0];
          up = sr; eh = up[31:0];
        end else begin
          el = ma / mb; eh = ma % mb;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                        input bit use_mf, input string tag);
    logic [31:0] eh, el;
    int elat, lat, k;
    model(mop, ma, mb, eh, el, elat);
    @(negedge clk);
    start = 1'b1; op = mop; a = ma; b = mb;
    @(posedge clk); #1;
    start = 1'b0;
    if (use_mf) mf_rd = 1'b1;
    lat = -1;
    k = 0;
    while (lat < 0 && k < 40) begin
      k++;
      @(posedge clk); #1;
      if (use_mf && k == 10) chk({tag, "_stall_mid"}, 32'(stall), 32'd1);
      if (done) lat = k;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (use_mf) chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    mf_rd = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          seen;

    // Reset state
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed operations
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_m3x5");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_max");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7d2");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100d7");

    // Divide by zero with a second start arriving while busy
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd7; b = 32'd0;
    @(posedge clk); #1;
    a = 32'd9; b = 32'd3;
    chk("dz_busy", 32'(busy), 32'd1);
    chk("dz_stall", 32'(stall), 32'd1);
    #2 start = 1'b0;
    @(posedge clk); #1;
    chk("dz_done", 32'(done), 32'd1);
    chk("dz_hi", hi, 32'd7);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("dz_ignored", 32'(busy), 32'd0);

    // Preload, start mult, flush mid-calculation
    @(negedge clk); mthi = 1'b1; a = 32'h1234;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; a = 32'h5678;
    @(negedge clk); mtlo = 1'b0;
    chk("mt_hi", hi, 32'h1234);
    chk("mt_lo", lo, 32'h5678);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("fl_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("fl_nodone", 32'(seen), 32'd0);
    chk("fl_hi", hi, 32'h1234);
    chk("fl_lo", lo, 32'h5678);

    // Asynchronous reset mid-calculation
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd11; b = 32'd13;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_hi", hi, 32'd0);
    chk("ar_lo", lo, 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, 1'b0, "multu_6x7");

    // Random operations against the model
    for (int n = 0; n < 16; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
